// File: rtl/arrow_judge_pkg.sv
// Shared definitions for the arrow judge: game-state encodings, arrow codes,
// judge FSM states and the arrow-code to direction-mask decode.
package arrow_pkg;

    localparam int STATE_BITS = 1;

    localparam logic [1:0] STATE_GAME  = 2'd0;
    localparam logic [1:0] STATE_PAUSE = 2'd1;
    localparam logic [1:0] STATE_RESET = 2'd2;

    localparam logic [4:0] ARROW_U    = 5'd10;
    localparam logic [4:0] ARROW_D    = 5'd11;
    localparam logic [4:0] ARROW_L    = 5'd12;
    localparam logic [4:0] ARROW_R    = 5'd13;
    localparam logic [4:0] ARROW_UD   = 5'd14;
    localparam logic [4:0] ARROW_UL   = 5'd15;
    localparam logic [4:0] ARROW_UR   = 5'd16;
    localparam logic [4:0] ARROW_DL   = 5'd17;
    localparam logic [4:0] ARROW_DR   = 5'd18;
    localparam logic [4:0] ARROW_LR   = 5'd19;
    localparam logic [4:0] ARROW_NONE = 5'd20;

    typedef enum logic [1:0] {
        FSM_RUN  = 2'd0,
        FSM_HOLD = 2'd1,
        FSM_OVER = 2'd2
    } judge_fsm_t;

    // Mask bit order is {up, down, left, right}.
    function automatic logic [3:0] direction_mask(input logic [4:0] code);
        logic [3:0] m;
        case (code)
            ARROW_U:  m = 4'b1000;
            ARROW_D:  m = 4'b0100;
            ARROW_L:  m = 4'b0010;
            ARROW_R:  m = 4'b0001;
            ARROW_UD: m = 4'b1100;
            ARROW_UL: m = 4'b1010;
            ARROW_UR: m = 4'b1001;
            ARROW_DL: m = 4'b0110;
            ARROW_DR: m = 4'b0101;
            ARROW_LR: m = 4'b0011;
            default:  m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/arrow_judge_if.sv
// Bundle of the arrow judge's game-side inputs and score/lives outputs.
interface arrow_judge_if #(
    parameter int STATE_BITS = 1
);
    logic                  metronome_clk;
    logic [STATE_BITS:0]   state;
    logic [4:0]            arrow3;
    logic                  btn_up;
    logic                  btn_down;
    logic                  btn_left;
    logic                  btn_right;
    logic [15:0]           score_bcd;
    logic [7:0]            combo;
    logic [2:0]            lives;
    logic                  hit_pulse;
    logic                  miss_pulse;
    logic                  game_over;

    modport master (
        output metronome_clk, state, arrow3, btn_up, btn_down, btn_left, btn_right,
        input  score_bcd, combo, lives, hit_pulse, miss_pulse, game_over
    );

    modport slave (
        input  metronome_clk, state, arrow3, btn_up, btn_down, btn_left, btn_right,
        output score_bcd, combo, lives, hit_pulse, miss_pulse, game_over
    );
endinterface

// File: rtl/arrow_judge_bcd_score_counter.sv
// Four-digit BCD accumulator: adds 1 or 2 per cycle, saturates at 9999,
// synchronous clear. Shared with the display path.
module bcd_score_counter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        add_one,
    input  logic        add_two,
    output logic [15:0] score
);
    logic [15:0] sum_s;
    logic        sat_s;

    // Ripple the increment through the digits; a carry out of the top digit saturates.
    always_comb begin
        logic [4:0] digit;
        logic [1:0] carry;
        sum_s = score;
        digit = 5'd0;
        if (add_two) begin
            carry = 2'd2;
        end else if (add_one) begin
            carry = 2'd1;
        end else begin
            carry = 2'd0;
        end
        for (int i = 0; i < 4; i++) begin
            digit = {1'b0, score[i*4 +: 4]} + {3'b000, carry};
            if (digit > 5'd9) begin
                sum_s[i*4 +: 4] = 4'(digit - 5'd10);
                carry           = 2'd1;
            end else begin
                sum_s[i*4 +: 4] = digit[3:0];
                carry           = 2'd0;
            end
        end
        sat_s = (carry != 2'd0);
    end

    // Score register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            score <= 16'h0000;
        end else if (clr) begin
            score <= 16'h0000;
        end else if (sat_s) begin
            score <= 16'h9999;
        end else begin
            score <= sum_s;
        end
    end

endmodule

// File: rtl/arrow_judge.sv
// Judges the bottom arrow against button presses on each metronome beat and
// tracks score, combo and lives. Optional macro: ARROW_JUDGE_COMBO_EN.
module arrow_judge
    import arrow_pkg::*;
#(
    parameter int STATE_BITS  = arrow_pkg::STATE_BITS,
    parameter int START_LIVES = 3,
    parameter int COMBO_BONUS = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    arrow_judge_if.slave  bus
);
    localparam logic [STATE_BITS:0] ST_GAME  = (STATE_BITS + 1)'(STATE_GAME);
    localparam logic [STATE_BITS:0] ST_RESET = (STATE_BITS + 1)'(STATE_RESET);
    localparam logic [2:0]          LIVES_INIT = 3'(START_LIVES);

    logic [2:0]  metro_sync_r;
    logic        tick_r;
    logic [3:0]  btn_meta_r, btn_sync_r, btn_prev_r, press_mask_r;
    logic [3:0]  edge_s, req_s;
    logic        st_game_s, st_reset_s, st_pause_s;
    logic        judge_en_s, hit_s, miss_s, bonus_s;
    logic [6:0]  combo_bin_s;
    logic [15:0] score_s;
    judge_fsm_t  fsm_r;
    logic [2:0]  lives_r;
    logic        hit_r, miss_r, over_r;

    assign st_game_s  = (bus.state == ST_GAME);
    assign st_reset_s = (bus.state == ST_RESET);
    assign st_pause_s = !st_game_s && !st_reset_s;
    assign edge_s     = btn_sync_r & ~btn_prev_r;

    // Metronome and button synchronisers; newest metronome sample enters at bit 2.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            metro_sync_r <= 3'b000;
            tick_r       <= 1'b0;
            btn_meta_r   <= 4'b0000;
            btn_sync_r   <= 4'b0000;
            btn_prev_r   <= 4'b0000;
        end else begin
            metro_sync_r <= {bus.metronome_clk, metro_sync_r[2:1]};
            tick_r       <= ~metro_sync_r[0] & metro_sync_r[1];
            btn_meta_r   <= {bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right};
            btn_sync_r   <= btn_meta_r;
            btn_prev_r   <= btn_sync_r;
        end
    end

    // Press mask: a press landing on the tick opens the next window.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            press_mask_r <= 4'b0000;
        end else if (st_reset_s || (fsm_r != FSM_RUN)) begin
            press_mask_r <= 4'b0000;
        end else if (tick_r) begin
            press_mask_r <= edge_s;
        end else begin
            press_mask_r <= press_mask_r | edge_s;
        end
    end

    // Beat judgement.
    always_comb begin
        req_s      = direction_mask(bus.arrow3);
        judge_en_s = tick_r && (fsm_r == FSM_RUN) && st_game_s;
        hit_s      = 1'b0;
        miss_s     = 1'b0;
        if (judge_en_s) begin
            hit_s  = (req_s != 4'b0000) && (press_mask_r == req_s);
            miss_s = !hit_s && ((req_s != 4'b0000) || (press_mask_r != 4'b0000));
        end else begin
            hit_s  = 1'b0;
            miss_s = 1'b0;
        end
    end

`ifdef ARROW_JUDGE_COMBO_EN
    localparam logic COMBO_EN = 1'b1;
    logic [7:0] combo_r;

    assign combo_bin_s = ({3'b000, combo_r[7:4]} * 7'd10) + {3'b000, combo_r[3:0]};
    assign bus.combo   = combo_r;

    // Two-digit BCD combo count, saturating at 99.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            combo_r <= 8'h00;
        end else if (st_reset_s || miss_s) begin
            combo_r <= 8'h00;
        end else if (hit_s && (combo_r != 8'h99)) begin
            if (combo_r[3:0] == 4'd9) begin
                combo_r <= {combo_r[7:4] + 4'd1, 4'd0};
            end else begin
                combo_r <= {combo_r[7:4], combo_r[3:0] + 4'd1};
            end
        end else begin
            combo_r <= combo_r;
        end
    end
`else
    localparam logic COMBO_EN = 1'b0;
    assign combo_bin_s = 7'd0;
    assign bus.combo   = 8'h00;
`endif

    assign bonus_s = COMBO_EN && (combo_bin_s >= 7'(COMBO_BONUS));

    bcd_score_counter u_score (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (st_reset_s),
        .add_one (hit_s && !bonus_s),
        .add_two (hit_s && bonus_s),
        .score   (score_s)
    );

    // Game FSM with lives, pulses and game_over.
    always_ff @(posedge clk) begin
        if (!rst_n || st_reset_s) begin
            fsm_r   <= FSM_RUN;
            lives_r <= LIVES_INIT;
            hit_r   <= 1'b0;
            miss_r  <= 1'b0;
            over_r  <= 1'b0;
        end else begin
            hit_r  <= 1'b0;
            miss_r <= 1'b0;
            case (fsm_r)
                FSM_RUN: begin
                    hit_r  <= hit_s;
                    miss_r <= miss_s;
                    if (miss_s) begin
                        lives_r <= lives_r - 3'd1;
                        if (lives_r == 3'd1) begin
                            fsm_r  <= FSM_OVER;
                            over_r <= 1'b1;
                        end else begin
                            fsm_r <= FSM_RUN;
                        end
                    end else if (st_pause_s) begin
                        fsm_r <= FSM_HOLD;
                    end else begin
                        fsm_r <= FSM_RUN;
                    end
                end
                FSM_HOLD: begin
                    if (st_game_s) begin
                        fsm_r <= FSM_RUN;
                    end else begin
                        fsm_r <= FSM_HOLD;
                    end
                end
                FSM_OVER: begin
                    fsm_r <= FSM_OVER;
                end
                default: begin
                    fsm_r <= FSM_RUN;
                end
            endcase
        end
    end

    assign bus.score_bcd  = score_s;
    assign bus.lives      = lives_r;
    assign bus.hit_pulse  = hit_r;
    assign bus.miss_pulse = miss_r;
    assign bus.game_over  = over_r;

endmodule

// File: tb/tb_arrow_judge.sv
// Table-driven bench for arrow_judge with a pulse scoreboard, plus a direct
// saturation test of bcd_score_counter.
module tb_arrow_judge;
    import arrow_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    arrow_judge_if #(.STATE_BITS(1)) bus ();

    arrow_judge dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic        sat_clr = 1'b0, sat_one = 1'b0, sat_two = 1'b0;
    logic [15:0] sat_score;

    bcd_score_counter u_sat (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (sat_clr),
        .add_one (sat_one),
        .add_two (sat_two),
        .score   (sat_score)
    );

    typedef struct {
        logic [1:0]  st;
        logic [4:0]  arrow;
        logic [3:0]  press;
        logic [1:0]  kind;     // 0 none, 1 hit, 2 miss
        logic [15:0] score;
        logic [7:0]  combo;
        logic [2:0]  lives;
        logic        over;
    } vec_t;

    typedef struct {
        logic [1:0]  kind;
        logic [15:0] score;
        logic [7:0]  combo;
        logic [2:0]  lives;
        logic        over;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   rise_cyc = 0;
    logic prev_pulse = 1'b0;

    always @(posedge clk) cyc++;

    function automatic logic [7:0] cmb(input logic [7:0] c);
`ifdef ARROW_JUDGE_COMBO_EN
        return c;
`else
        return 8'h00;
`endif
    endfunction

    function automatic vec_t mk(input logic [1:0] st, input logic [4:0] a, input logic [3:0] p,
                                input logic [1:0] k, input logic [15:0] s, input logic [7:0] c,
                                input logic [2:0] l, input logic o);
        vec_t v;
        v.st = st; v.arrow = a; v.press = p; v.kind = k;
        v.score = s; v.combo = c; v.lives = l; v.over = o;
        return v;
    endfunction

    // Scoreboard: every pulse pops one expectation and checks latency and outputs.
    always @(negedge clk) begin
        logic pulse;
        exp_t e;
        pulse = bus.hit_pulse || bus.miss_pulse;
        if (rst_n && prev_pulse) begin
            checks++;
            if (pulse) begin
                errors++;
                $display("FAIL pulse_width: pulse high %0d cycles in a row, required 1", 2);
            end
        end
        if (rst_n && pulse) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: hit=%0b miss=%0b, required no pulse",
                         bus.hit_pulse, bus.miss_pulse);
            end else begin
                e = sb.pop_front();
                if ({bus.hit_pulse, bus.miss_pulse} != ((e.kind == 2'd1) ? 2'b10 : 2'b01) ||
                    bus.score_bcd != e.score || bus.combo != e.combo ||
                    bus.lives != e.lives || bus.game_over != e.over || (cyc - rise_cyc) != 4) begin
                    errors++;
                    $display("FAIL pulse_event: got hit=%0b miss=%0b score=%h combo=%h lives=%0d over=%0b lat=%0d, required kind=%0d score=%h combo=%h lives=%0d over=%0b lat=4",
                             bus.hit_pulse, bus.miss_pulse, bus.score_bcd, bus.combo, bus.lives,
                             bus.game_over, cyc - rise_cyc, e.kind, e.score, e.combo, e.lives, e.over);
                end
            end
        end
        prev_pulse = rst_n && pulse;
    end

    task automatic check_outs(input string name, input logic [15:0] s, input logic [7:0] c,
                              input logic [2:0] l, input logic o);
        checks++;
        if (bus.score_bcd != s || bus.combo != c || bus.lives != l || bus.game_over != o ||
            bus.hit_pulse || bus.miss_pulse) begin
            errors++;
            $display("FAIL %s: got score=%h combo=%h lives=%0d over=%0b hit=%0b miss=%0b, required score=%h combo=%h lives=%0d over=%0b no pulse",
                     name, bus.score_bcd, bus.combo, bus.lives, bus.game_over,
                     bus.hit_pulse, bus.miss_pulse, s, c, l, o);
        end
    endtask

    task automatic press(input logic [3:0] m);
        @(negedge clk);
        {bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right} = m;
        repeat (3) @(negedge clk);
        {bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right} = 4'b0000;
        repeat (3) @(negedge clk);
    endtask

    task automatic beat();
        @(negedge clk);
        bus.metronome_clk = 1'b1;
        rise_cyc = cyc;
        repeat (8) @(negedge clk);
        bus.metronome_clk = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            exp_t e;
            bus.state  = vecs[i].st;
            bus.arrow3 = vecs[i].arrow;
            press(vecs[i].press);
            if (vecs[i].kind != 2'd0) begin
                e.kind = vecs[i].kind; e.score = vecs[i].score; e.combo = vecs[i].combo;
                e.lives = vecs[i].lives; e.over = vecs[i].over;
                sb.push_back(e);
            end
            beat();
            checks++;
            if (sb.size() != 0) begin
                errors++;
                $display("FAIL row%0d_drain: %0d expected pulses outstanding, required 0", i, sb.size());
                sb.delete();
            end
            check_outs($sformatf("row%0d_state", i), vecs[i].score, vecs[i].combo,
                       vecs[i].lives, vecs[i].over);
        end
    endtask

    initial begin
        bus.metronome_clk = 1'b0;
        bus.state = 2'd0;
        bus.arrow3 = ARROW_NONE;
        {bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right} = 4'b0000;

        vecs.push_back(mk(2'd0, 5'd15, 4'b1010, 2'd1, 16'h0001, cmb(8'h01), 3'd3, 1'b0)); // 0
        vecs.push_back(mk(2'd0, 5'd17, 4'b0100, 2'd2, 16'h0001, 8'h00,      3'd2, 1'b0));
        vecs.push_back(mk(2'd0, 5'd20, 4'b0001, 2'd2, 16'h0001, 8'h00,      3'd1, 1'b0));
        vecs.push_back(mk(2'd2, 5'd10, 4'b1000, 2'd0, 16'h0000, 8'h00,      3'd3, 1'b0)); // reset on tick
        vecs.push_back(mk(2'd0, 5'd10, 4'b1000, 2'd1, 16'h0001, cmb(8'h01), 3'd3, 1'b0)); // 4
        vecs.push_back(mk(2'd0, 5'd14, 4'b1100, 2'd1, 16'h0002, cmb(8'h02), 3'd3, 1'b0));
        vecs.push_back(mk(2'd0, 5'd19, 4'b0011, 2'd1, 16'h0003, cmb(8'h03), 3'd3, 1'b0));
        vecs.push_back(mk(2'd0, 5'd16, 4'b1001, 2'd1, 16'h0004, cmb(8'h04), 3'd3, 1'b0));
        vecs.push_back(mk(2'd0, 5'd13, 4'b0001, 2'd1, 16'h0005, cmb(8'h05), 3'd3, 1'b0));
`ifdef ARROW_JUDGE_COMBO_EN
        vecs.push_back(mk(2'd0, 5'd18, 4'b0101, 2'd1, 16'h0007, 8'h06,      3'd3, 1'b0)); // 9
`else
        vecs.push_back(mk(2'd0, 5'd18, 4'b0101, 2'd1, 16'h0006, 8'h00,      3'd3, 1'b0)); // 9
`endif
        vecs.push_back(mk(2'd0, 5'd11, 4'b0000, 2'd2, vecs[9].score, 8'h00, 3'd2, 1'b0)); // 10
        vecs.push_back(mk(2'd0, 5'd12, 4'b0001, 2'd2, vecs[9].score, 8'h00, 3'd1, 1'b0));
        vecs.push_back(mk(2'd0, 5'd20, 4'b0100, 2'd2, vecs[9].score, 8'h00, 3'd0, 1'b1));
        vecs.push_back(mk(2'd0, 5'd10, 4'b1000, 2'd0, vecs[9].score, 8'h00, 3'd0, 1'b1)); // 13
        vecs.push_back(mk(2'd0, 5'd20, 4'b0000, 2'd0, 16'h0000, 8'h00,      3'd3, 1'b0)); // 14
        vecs.push_back(mk(2'd1, 5'd10, 4'b1000, 2'd0, 16'h0000, 8'h00,      3'd3, 1'b0));
        vecs.push_back(mk(2'd1, 5'd11, 4'b0100, 2'd0, 16'h0000, 8'h00,      3'd3, 1'b0));
        vecs.push_back(mk(2'd1, 5'd20, 4'b0001, 2'd0, 16'h0000, 8'h00,      3'd3, 1'b0));
        vecs.push_back(mk(2'd0, 5'd12, 4'b0010, 2'd1, 16'h0001, cmb(8'h01), 3'd3, 1'b0)); // 18
        vecs.push_back(mk(2'd3, 5'd12, 4'b0010, 2'd0, 16'h0001, cmb(8'h01), 3'd3, 1'b0));
        vecs.push_back(mk(2'd0, 5'd17, 4'b0110, 2'd1, 16'h0002, cmb(8'h02), 3'd3, 1'b0)); // 20

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outs("reset", 16'h0000, 8'h00, 3'd3, 1'b0);
        rst_n = 1'b1;

        run_rows(0, 13);

        // One-cycle RESET pulse clears a game-over.
        @(negedge clk);
        bus.state = 2'd2;
        @(negedge clk);
        bus.state = 2'd0;
        @(negedge clk);
        check_outs("state_reset", 16'h0000, 8'h00, 3'd3, 1'b0);

        run_rows(14, 20);

        // Saturation and digit roll on a standalone counter.
        @(negedge clk); sat_clr = 1'b1;
        @(negedge clk); sat_clr = 1'b0; sat_two = 1'b1;
        repeat (6) @(negedge clk);
        sat_two = 1'b0; sat_one = 1'b1;
        repeat (9) @(negedge clk);
        sat_one = 1'b0;
        checks++;
        if (sat_score != 16'h0021) begin
            errors++;
            $display("FAIL bcd_roll: got %h, required 0021", sat_score);
        end
        sat_clr = 1'b1;
        @(negedge clk); sat_clr = 1'b0; sat_two = 1'b1;
        repeat (4999) @(negedge clk);
        sat_two = 1'b0;
        checks++;
        if (sat_score != 16'h9998) begin
            errors++;
            $display("FAIL bcd_9998: got %h, required 9998", sat_score);
        end
        sat_two = 1'b1;
        @(negedge clk); sat_two = 1'b0;
        checks++;
        if (sat_score != 16'h9999) begin
            errors++;
            $display("FAIL bcd_sat_two: got %h, required 9999", sat_score);
        end
        sat_one = 1'b1;
        @(negedge clk); sat_one = 1'b0;
        checks++;
        if (sat_score != 16'h9999) begin
            errors++;
            $display("FAIL bcd_sat_one: got %h, required 9999", sat_score);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/arrow_judge.md
Name: arrow_judge

Overview:
- Downstream consumer of the four-slot arrow shift buffer.
- On each metronome beat, judges the bottom slot (arrow3) against the direction buttons pressed during the preceding beat window.
- Maintains a 4-digit BCD score, a combo count, and remaining lives; raises game_over.
- Feeds the score/lives display and the top-level game state controller.

Parameters:
- STATE_BITS, 1, MSB index of the state bus (bus is [STATE_BITS:0]).
- START_LIVES, 3, lives loaded on reset and on STATE_RESET (1..7).
- COMBO_BONUS, 5, combo count at or above which a hit scores 2 instead of 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- metronome_clk  in  1  beat clock, asynchronous to clk, slow square wave.
- state  in  STATE_BITS+1  game state; 0=GAME, 1=PAUSE, 2=RESET.
- arrow3  in  5  bottom arrow code from the shift buffer; 10..19 = arrow, 20 = none.
- btn_up, btn_down, btn_left, btn_right  in  1 each  raw debounced buttons, asynchronous.
- score_bcd  out  16  four BCD digits, [15:12] = thousands.
- combo  out  8  two BCD digits, consecutive hits.
- lives  out  3  remaining lives.
- hit_pulse  out  1  one-cycle pulse on a judged hit.
- miss_pulse  out  1  one-cycle pulse on a judged miss.
- game_over  out  1  high when lives reach 0.

Behaviour:
- **Reset (rst_n=0 at a clk edge):** score_bcd=0, combo=0, lives=START_LIVES, pulses=0, game_over=0, press mask=0, synchronisers=0, FSM=RUN.
- **Beat tick:**
  - 3-bit shift synchroniser on metronome_clk; tick is registered as ~s[0] & s[1].
  - This is the same latency as the buffer, so tick is high in the cycle before the buffer shifts, and arrow3 still holds the pre-shift (bottom) arrow.
- **Buttons:**
  - Each button uses a 2-flop synchroniser plus rising-edge detect.
  - The press mask {up,down,left,right} ORs in every rising edge.
  - A press edge coincident with tick goes into the next window.
- **Required mask decode:**
  - 10=1000, 11=0100, 12=0010, 13=0001.
  - 14=1100, 15=1010, 16=1001, 17=0110, 18=0101, 19=0011.
  - Any other code = 0000.
- **Judging (on tick, FSM=RUN, state=GAME):**
  - req=0, mask=0: no event.
  - req=0, mask≠0: miss (false press).
  - req≠0, mask==req: hit.
  - Otherwise: miss.
  - The press mask clears on every tick, judged or not.
- **Hit:**
  - score += (combo>=COMBO_BONUS ? 2 : 1), BCD-correct, saturating at 9999.
  - combo += 1, saturating at 99.
  - hit_pulse is asserted the cycle after tick.
- **Miss:**
  - combo=0; lives -= 1; miss_pulse is asserted the cycle after tick.
  - If lives becomes 0, FSM → OVER and game_over=1 in the same cycle.
- **FSM states RUN, HOLD, OVER:**
  - RUN → HOLD when state=PAUSE.
  - HOLD → RUN when state=GAME.
  - Any state → RUN with full clear (as reset) when state=RESET.
  - OVER holds all outputs until state=RESET.
  - In HOLD and OVER: ticks are not judged, the press mask is held at 0, and no pulses are issued.
- **Undefined state value (3):** treated as PAUSE.
- **state=RESET coincident with tick:** the reset clear wins; no pulse.

Optional Feature:
- Macro: ARROW_JUDGE_COMBO_EN.
- Defined: combo tracking and the COMBO_BONUS double score are as above.
- Undefined: the combo register is removed, the combo output is tied to 0, and every hit scores exactly 1.

Decomposition:
- Shared package arrow_pkg holds:
  - state encodings (STATE_GAME/PAUSE/RESET, STATE_BITS);
  - arrow codes 10..20 (ARROW_NONE=20);
  - the code→direction-mask function;
  - the FSM state enum.
- One sub-module: bcd_score_counter.
  - 4-digit BCD accumulator with add-1/add-2 input, saturation at 9999, and synchronous clear.
  - Reused by the display path.

Test Plan:
1. **Reset:** rst_n=0 for 2 cycles → score_bcd=0000, combo=00, lives=3, game_over=0, no pulses.
2. **Single hit:** GAME, arrow3=15, press up and left within the window, then tick → hit_pulse one cycle after tick; score_bcd=0001, combo=01.
3. **Wrong press:** arrow3=17, press only down, tick → miss_pulse; lives=2, combo=00. Then arrow3=20, press right, tick → miss; lives=1.
4. **Combo bonus:** 5 consecutive hits then a 6th → scores go 1,2,3,4,5,7 (0007); combo=06. Without ARROW_JUDGE_COMBO_EN the 6th score is 0006 and combo stays 00.
5. **Game over:** START_LIVES=3, three misses → game_over=1, lives=0. A further correct hit is ignored (score unchanged). state=RESET for one cycle → lives=3, game_over=0, score=0000.
6. **Pause and edge cases:**
   - state=PAUSE across 3 ticks with presses → no pulses, score unchanged.
   - Back to GAME, arrow3=20 with no press, tick → no event.
   - score preloaded to 9998 plus a bonus hit → 9999 (saturated).
